uart_echo_bridge: RTL and testbench

Single-clock, parametrised receive-to-transmit bridge between the UART receiver and transmitter. Buffers received words in a DEPTH-entry FIFO, releases them to the transmitter either immediately (pass mode) or a whole line at a time (line mode), and reports overflow. Also provides the board heartbeat. Successor to the dual-clock echo path: both UART sides run from one clock.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_echo_bridge.sv | 151 +++++++++++++++
 tb/tb_uart_echo_bridge.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART echo path.
// Holds the default word width, default EOL word and transmit FSM states.
package uart_pkg;

  localparam int UART_DATA_LENGTH = 8;
  localparam logic [7:0] UART_EOL = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ARM,
    WAIT
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered q, wrap-bit pointers.
// Ports: clk_i/rst_i, clr, we/d write, re/q read, level/full/empty status.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] q,
  output logic [AW:0]           level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_ok;
  logic        rd_ok;

  // Status comes straight from the pointer flops.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_ok = we && !full && !clr;
  assign rd_ok = re && !empty && !clr;

  always_ff @(posedge clk_i) begin
    if (wr_ok)
      mem[wr_ptr[AW-1:0]] <= d;
  end

  // q is not cleared by clr so a word already popped stays visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q      <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        q      <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_echo_bridge.sv
// uart_echo_bridge: rx-to-tx FIFO bridge, pass/line release, heartbeat.
// Ports: rx_d_i/rx_v_i in, tx_d_o/tx_v_o out, tx_busy_i, status, hb_o.
module uart_echo_bridge
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_LENGTH,
  parameter int DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] EOL = DATA_WIDTH'(UART_EOL),
  parameter int HB_DIV     = 6000000,
  localparam int AW        = $clog2(DEPTH),
  localparam int HBW       = (HB_DIV > 1) ? $clog2(HB_DIV) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] rx_d_i,
  input  logic                  rx_v_i,
  input  logic                  tx_busy_i,
  input  logic                  line_mode_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] tx_d_o,
  output logic                  tx_v_o,
  output logic [AW:0]           level_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [7:0]            drop_cnt_o,
  output logic                  hb_o
);

  tx_state_t       state;
  logic            fifo_we;
  logic            fifo_re;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     eol_cnt;
  logic            drain;
  logic            drop;
  logic            st_eol;
  logic            pop_eol;
  logic            releasable;
  logic [HBW-1:0]  hb_cnt;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (flush_i),
    .we   (fifo_we),
    .d    (rx_d_i),
    .re   (fifo_re),
    .q    (tx_d_o),
    .level(level_o),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign full_o  = fifo_full;
  assign empty_o = fifo_empty;

  assign fifo_we = rx_v_i && !flush_i;
  assign drop    = rx_v_i && !flush_i && fifo_full;
  assign st_eol  = fifo_we && !fifo_full && (rx_d_i == EOL);
  // The popped word shows on q in SEND, so the decrement lands there.
  assign pop_eol = (state == SEND) && (tx_d_o == EOL) && (eol_cnt != '0);

  // A line that fills the buffer is drained completely, otherwise
  // it could never be released.
  assign releasable = !fifo_empty &&
                      (!line_mode_i || (eol_cnt != '0) ||
                       fifo_full || drain);

  assign fifo_re = (state == IDLE) && releasable &&
                   !tx_busy_i && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eol_cnt <= '0;
    end else if (flush_i) begin
      eol_cnt <= '0;
    end else if (st_eol && !pop_eol) begin
      eol_cnt <= eol_cnt + 1'b1;
    end else if (pop_eol && !st_eol) begin
      eol_cnt <= eol_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drain <= 1'b0;
    end else if (flush_i) begin
      drain <= 1'b0;
    end else if (fifo_full) begin
      drain <= 1'b1;
    end else if (fifo_empty) begin
      drain <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (flush_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 8'hFF)
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      tx_v_o <= 1'b0;
    end else begin
      tx_v_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_re) begin
            state  <= SEND;
            tx_v_o <= 1'b1;
          end
        end
        SEND: state <= ARM;
        ARM:  state <= WAIT;
        WAIT: begin
          if (!tx_busy_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hb_cnt <= '0;
      hb_o   <= 1'b0;
    end else if (hb_cnt == HBW'(HB_DIV - 1)) begin
      hb_cnt <= '0;
      hb_o   <= ~hb_o;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_echo_bridge.sv
// tb_uart_echo_bridge: scenario tasks plus random traffic vs a queue model.
// The transmitter is modelled as a busy counter started by each tx_v_o.
module tb_uart_echo_bridge;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int HB    = 5;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] EOLW = 8'h0D;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] rx_d_i = '0;
  logic          rx_v_i = 1'b0;
  logic          tx_busy_i = 1'b0;
  logic          line_mode_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [DW-1:0] tx_d_o;
  logic          tx_v_o;
  logic [LW-1:0] level_o;
  logic          empty_o;
  logic          full_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;
  logic          hb_o;

  uart_echo_bridge #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .EOL       (EOLW),
    .HB_DIV    (HB)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rx_d_i     (rx_d_i),
    .rx_v_i     (rx_v_i),
    .tx_busy_i  (tx_busy_i),
    .line_mode_i(line_mode_i),
    .flush_i    (flush_i),
    .tx_d_o     (tx_d_o),
    .tx_v_o     (tx_v_o),
    .level_o    (level_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .hb_o       (hb_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] txq[$];
  int         txc[$];
  int         ovl = 0;
  int         bcnt = 0;
  int         busy_len = 10;
  bit         busy_hold = 1'b0;

  // Transmitter model and output capture, on the falling edge.
  always @(negedge clk) begin
    if (tx_v_o) begin
      txq.push_back(tx_d_o);
      txc.push_back(cyc);
      if (tx_busy_i) ovl++;
    end
    if (busy_hold) begin
      tx_busy_i = 1'b1;
    end else if (tx_v_o) begin
      bcnt = busy_len;
      tx_busy_i = 1'b1;
    end else if (bcnt > 0) begin
      bcnt--;
      tx_busy_i = (bcnt != 0);
    end else begin
      tx_busy_i = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_d_i = b;
    rx_v_i = 1'b1;
    tick(1);
    rx_v_i = 1'b0;
  endtask

  task automatic flush();
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
  endtask

  task automatic clear_cap();
    txq.delete();
    txc.delete();
    ovl = 0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (txq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  localparam logic [22:0] RST_VEC =
    {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

  task automatic test_reset();
    logic [22:0] got;
    tick(2);
    got = {tx_d_o, tx_v_o, level_o, empty_o, full_o,
           overflow_o, drop_cnt_o, hb_o};
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", got, RST_VEC);
    end
  endtask

  task automatic test_heartbeat();
    logic want;
    rst_i = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      want = ((k / HB) % 2) == 1;
      checks++;
      if (hb_o !== want) begin
        errors++;
        $display("FAIL hb_k%0d: got %b want %b", k, hb_o, want);
      end
    end
  endtask

  task automatic test_pass();
    int c0;
    flush();
    line_mode_i = 1'b0;
    busy_len = 10;
    clear_cap();
    c0 = cyc;
    send(8'h41);
    send(8'h42);
    send(8'h43);
    wait_tx(3, 200);
    checks++;
    if (txq.size() !== 3) begin
      errors++;
      $display("FAIL pass_count: got %0d want 3", txq.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (txq[i] !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL pass_word%0d: got %h want %h", i, txq[i], 8'h41 + i);
      end
    end
    checks++;
    if (txc[0] !== c0 + 2) begin
      errors++;
      $display("FAIL pass_latency: got %0d want %0d", txc[0] - c0, 2);
    end
    checks++;
    if ((txc[1] - txc[0] < 10) || (txc[2] - txc[1] < 10)) begin
      errors++;
      $display("FAIL pass_spacing: got %0d,%0d want >=10",
               txc[1] - txc[0], txc[2] - txc[1]);
    end
    checks++;
    if (ovl !== 0) begin
      errors++;
      $display("FAIL pass_busy_overlap: got %0d want 0", ovl);
    end
    tick(20);
    checks++;
    if (empty_o !== 1'b1) begin
      errors++;
      $display("FAIL pass_empty: got %b want 1", empty_o);
    end
  endtask

  task automatic test_line();
    int c0;
    flush();
    line_mode_i = 1'b1;
    busy_len = 4;
    clear_cap();
    send(8'h68);
    send(8'h69);
    tick(100);
    checks++;
    if (txq.size() !== 0) begin
      errors++;
      $display("FAIL line_hold: got %0d words want 0", txq.size());
    end
    checks++;
    if (level_o !== 3'd2) begin
      errors++;
      $display("FAIL line_level: got %0d want 2", level_o);
    end
    c0 = cyc;
    send(EOLW);
    wait_tx(3, 100);
    checks++;
    if (txq.size() !== 3 || txq[0] !== 8'h68 ||
        txq[1] !== 8'h69 || txq[2] !== EOLW) begin
      errors++;
      $display("FAIL line_words: got n=%0d %h %h %h want 68 69 0d",
               txq.size(), txq[0], txq[1], txq[2]);
    end
    checks++;
    if (txc[0] !== c0 + 2) begin
      errors++;
      $display("FAIL line_latency: got %0d want 2", txc[0] - c0);
    end
    tick(20);
    checks++;
    if (empty_o !== 1'b1 || dut.eol_cnt !== '0) begin
      errors++;
      $display("FAIL line_drained: got empty=%b eol=%0d want 1 0",
               empty_o, dut.eol_cnt);
    end
  endtask

  task automatic test_line_full();
    flush();
    line_mode_i = 1'b1;
    busy_len = 3;
    clear_cap();
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
    wait_tx(4, 200);
    checks++;
    if (txq.size() !== 4) begin
      errors++;
      $display("FAIL lfull_count: got %0d want 4", txq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txq[i] !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL lfull_word%0d: got %h want %h", i, txq[i], 8'h10 + i);
      end
    end
    tick(10);
    checks++;
    if (empty_o !== 1'b1) begin
      errors++;
      $display("FAIL lfull_empty: got %b want 1", empty_o);
    end
  endtask

  task automatic test_overflow();
    flush();
    line_mode_i = 1'b0;
    busy_hold = 1'b1;
    tick(1);
    clear_cap();
    for (int i = 0; i < 7; i++) send(8'(8'h60 + i));
    checks++;
    if (level_o !== 3'd4 || full_o !== 1'b1 ||
        overflow_o !== 1'b1 || drop_cnt_o !== 8'd3) begin
      errors++;
      $display("FAIL ovf_status: got lvl=%0d full=%b ovf=%b drop=%0d want 4 1 1 3",
               level_o, full_o, overflow_o, drop_cnt_o);
    end
    checks++;
    if (txq.size() !== 0) begin
      errors++;
      $display("FAIL ovf_held: got %0d words want 0", txq.size());
    end
    busy_len = 2;
    busy_hold = 1'b0;
    wait_tx(4, 200);
    tick(20);
    checks++;
    if (txq.size() !== 4) begin
      errors++;
      $display("FAIL ovf_count: got %0d want 4", txq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txq[i] !== 8'(8'h60 + i)) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h want %h", i, txq[i], 8'h60 + i);
      end
    end
    checks++;
    if (overflow_o !== 1'b1 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b empty=%b want 1 1",
               overflow_o, empty_o);
    end
  endtask

  task automatic test_saturation();
    flush();
    checks++;
    if (overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL sat_preflush: got ovf=%b drop=%0d want 0 0",
               overflow_o, drop_cnt_o);
    end
    busy_hold = 1'b1;
    tick(1);
    clear_cap();
    for (int i = 0; i < 304; i++) send(8'(i));
    checks++;
    if (drop_cnt_o !== 8'd255 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_count: got drop=%0d full=%b want 255 1",
               drop_cnt_o, full_o);
    end
    flush();
    checks++;
    if (drop_cnt_o !== 8'd0 || overflow_o !== 1'b0 ||
        level_o !== 3'd0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_flush: got drop=%0d ovf=%b lvl=%0d empty=%b want 0 0 0 1",
               drop_cnt_o, overflow_o, level_o, empty_o);
    end
    busy_hold = 1'b0;
    tick(40);
    checks++;
    if (txq.size() !== 0) begin
      errors++;
      $display("FAIL sat_no_tx: got %0d words want 0", txq.size());
    end
  endtask

  task automatic test_reset_wait();
    logic [22:0] got;
    int n0;
    flush();
    line_mode_i = 1'b0;
    busy_len = 30;
    clear_cap();
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i));
    tick(2);
    checks++;
    if (level_o !== 3'd3 || txq.size() !== 1) begin
      errors++;
      $display("FAIL rstw_pre: got lvl=%0d tx=%0d want 3 1",
               level_o, txq.size());
    end
    rst_i = 1'b1;
    #1;
    got = {tx_d_o, tx_v_o, level_o, empty_o, full_o,
           overflow_o, drop_cnt_o, hb_o};
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL rstw_values: got %h want %h", got, RST_VEC);
    end
    tick(1);
    rst_i = 1'b0;
    n0 = txq.size();
    tick(60);
    checks++;
    if (txq.size() !== n0) begin
      errors++;
      $display("FAIL rstw_quiet: got %0d words want %0d", txq.size(), n0);
    end
    send(8'hB5);
    wait_tx(n0 + 1, 100);
    checks++;
    if (txq.size() !== n0 + 1 || txq[n0] !== 8'hB5) begin
      errors++;
      $display("FAIL rstw_new: got n=%0d %h want %0d b5",
               txq.size(), txq[n0], n0 + 1);
    end
  endtask

  task automatic test_random(input bit lm);
    logic [7:0] exp[$];
    logic [7:0] d;
    int sent;
    int guard;
    flush();
    line_mode_i = lm;
    busy_len = $urandom_range(1, 6);
    clear_cap();
    sent = 0;
    for (int i = 0; i < 41; i++) begin
      tick($urandom_range(0, 3));
      guard = 0;
      while (sent - txq.size() >= DEPTH && guard < 500) begin
        tick(1);
        guard++;
      end
      d = 8'($urandom_range(0, 255));
      if (lm && $urandom_range(0, 3) == 0) d = EOLW;
      if (lm && i == 40) d = EOLW;
      exp.push_back(d);
      send(d);
      sent++;
    end
    wait_tx(exp.size(), 3000);
    checks++;
    if (txq.size() !== exp.size()) begin
      errors++;
      $display("FAIL rand%0d_count: got %0d want %0d",
               lm, txq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (txq[i] !== exp[i]) begin
        errors++;
        $display("FAIL rand%0d_word%0d: got %h want %h",
                 lm, i, txq[i], exp[i]);
      end
    end
    checks++;
    if (overflow_o !== 1'b0 || ovl !== 0) begin
      errors++;
      $display("FAIL rand%0d_clean: got ovf=%b overlap=%0d want 0 0",
               lm, overflow_o, ovl);
    end
    tick(20);
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_pass();
    test_line();
    test_line_full();
    test_overflow();
    test_saturation();
    test_reset_wait();
    test_random(1'b0);
    test_random(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
